reg_f_loader: RTL and testbench
===============================

Name: reg_f_loader

Overview:
- Bulk writer for the CPU register file.
- Accepts a stream of SIZE data words over a valid/ready handshake and writes them into reg_f at consecutive addresses 0..SIZE-1 through reg_f's IN/EN/WR/SEL write interface.
- Then reads every register back through OUT and checks an XOR checksum.
- Used at boot and by benches to preload reg_f. Owns reg_f's write port while BUSY.

Parameters:
- WIDTH, 8, data word width; must equal reg_f WIDTH.
- SIZE, 9, number of registers; must equal reg_f SIZE; minimum 2.
- SW, $clog2(SIZE), select width; derived, not overridden.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- START  in  1  one-cycle request to begin a load; honoured only in IDLE.
- ABORT  in  1  return to IDLE from any state; takes priority over all other inputs except RST.
- DIN  in  WIDTH  stream data word.
- DIN_VALID  in  1  DIN holds a valid word.
- DIN_READY  out  1  loader accepts DIN this cycle.
- RF_IN  out  WIDTH  write data to reg_f IN.
- RF_EN  out  1  reg_f enable.
- RF_WR  out  1  reg_f write strobe.
- RF_SEL  out  SW  reg_f register select.
- RF_OUT  in  WIDTH  reg_f OUT, combinational read of RF_SEL when RF_EN=1.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse at end of verify.
- ERR  out  1  checksum mismatch; sticky until the next START or RST.
- COUNT  out  SW+1  words written in current load.

Behaviour:
- Registered outputs; reset values are all 0: DIN_READY, RF_IN, RF_EN, RF_WR, RF_SEL, BUSY, DONE, ERR, COUNT. Internal wsum and rsum are also 0. State resets to IDLE.
- States: IDLE, LOAD, VERIFY, CHECK.
- IDLE:
  - Outputs quiescent: RF_EN=0, RF_WR=0, DIN_READY=0.
  - START=1 -> LOAD next cycle. COUNT, RF_SEL, wsum, rsum and ERR clear at the same time.
- LOAD:
  - DIN_READY=1 except on the cycle after the final acceptance.
  - A beat is accepted when DIN_VALID and DIN_READY are both 1 at a rising edge. On that edge:
    - RF_IN<=DIN, RF_SEL<=COUNT[SW-1:0], RF_EN<=1, RF_WR<=1.
    - wsum<=wsum^DIN, COUNT<=COUNT+1.
  - reg_f therefore writes one edge after acceptance; write latency is one cycle.
  - No beat accepted: RF_WR<=0, RF_EN<=0, COUNT holds. Gaps in DIN_VALID of any length are legal.
  - When the beat with COUNT=SIZE-1 is accepted, DIN_READY drops on the next edge. After that final write completes, go to VERIFY with RF_SEL<=0, RF_EN<=1, RF_WR<=0.
- VERIFY:
  - Each cycle: rsum<=rsum^RF_OUT, RF_SEL<=RF_SEL+1.
  - After sampling RF_SEL=SIZE-1, go to CHECK. RF_SEL never exceeds SIZE-1, so there is no wrap into unimplemented addresses.
- CHECK (one cycle):
  - ERR<=(rsum!=wsum), DONE<=1, RF_EN<=0.
  - Next state IDLE; DONE is 0 again on the following cycle.
- ABORT:
  - Next cycle: IDLE with RF_EN=0, RF_WR=0, DIN_READY=0, BUSY=0, DONE=0.
  - COUNT holds the number of words already written. Registers already written keep their data.
- START outside IDLE is ignored.
- START and ABORT in the same IDLE cycle: ABORT wins and the loader stays in IDLE.
- RST mid-load: everything returns to reset values on that edge. The reg_f contents are not touched.
- COUNT is one bit wider than SEL so that COUNT=SIZE is representable.
- All XOR sums are WIDTH bits.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'd0, LOAD=2'd1, VERIFY=2'd2, CHECK=2'd3) and the default WIDTH/SIZE, so reg_f and the loader agree.
- One sub-module is natural: xor_acc, a WIDTH-bit XOR accumulator with clear and enable. It is instantiated twice, for wsum and rsum.
- The FSM and address counter stay in reg_f_loader.

Test Plan:
- Basic load: WIDTH=8, SIZE=9, reg_f attached. START, then DIN=1..9 with DIN_VALID held high -> RF_WR pulses at SEL 0..8 one cycle after each acceptance. Reading reg_f afterwards returns 1..9. DONE pulses once, ERR=0, COUNT=9.
- Throttled stream: DIN_VALID toggles 1,0,0,1,... -> exactly 9 writes in order. COUNT increments only on accepted beats. No write on gap cycles.
- Corrupted readback: the bench forces RF_OUT bit0 inverted while RF_SEL=4 in VERIFY -> ERR=1 with the DONE pulse. ERR stays 1 through IDLE and clears on the next START.
- ABORT after 4 beats: next cycle BUSY=0, RF_WR=0, COUNT=4. Registers 0..3 hold data, registers 4..8 are unchanged. DONE is never pulsed.
- RST during VERIFY: all outputs are 0 the next cycle and the state is IDLE. A following START plus 9 beats completes normally with ERR=0.
- START held high through a whole load: no restart mid-load. After DONE, the loader re-enters LOAD from IDLE on the next cycle.

Source files
------------

// File: rtl/reg_f_loader_pkg.sv
// Shared definitions for reg_f and its bulk loader: default geometry and the
// loader state encoding, so both sides agree on WIDTH/SIZE.
package reg_f_loader_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_SIZE  = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        CHECK  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/reg_f_loader_xor_acc.sv
// WIDTH-bit XOR accumulator with synchronous clear and enable; clear wins
// over enable so a new load always starts from zero.
module reg_f_loader_xor_acc
    import reg_f_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q ^ din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/reg_f_loader.sv
// Bulk writer for reg_f: streams SIZE words into registers 0..SIZE-1, then
// reads them all back and compares XOR checksums of written and read data.
module reg_f_loader
    import reg_f_loader_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int SIZE  = DEFAULT_SIZE,
    localparam int SW    = $clog2(SIZE)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic [WIDTH-1:0] RF_IN,
    output logic             RF_EN,
    output logic             RF_WR,
    output logic [SW-1:0]    RF_SEL,
    input  logic [WIDTH-1:0] RF_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [SW:0]      COUNT
);

    localparam logic [SW:0]   LAST_COUNT = (SW+1)'(SIZE - 1);
    localparam logic [SW-1:0] LAST_SEL   = SW'(SIZE - 1);

    loader_state_t    state_q, state_d;
    logic             din_ready_q, din_ready_d;
    logic [WIDTH-1:0] rf_in_q, rf_in_d;
    logic             rf_en_q, rf_en_d;
    logic             rf_wr_q, rf_wr_d;
    logic [SW-1:0]    rf_sel_q, rf_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [SW:0]      count_q, count_d;

    logic             sum_clr;
    logic             wsum_en;
    logic             rsum_en;
    logic [WIDTH-1:0] wsum;
    logic [WIDTH-1:0] rsum;

    // ABORT overrides everything but RST; every branch below assumes it is low.
    always_comb begin
        state_d     = state_q;
        din_ready_d = din_ready_q;
        rf_in_d     = rf_in_q;
        rf_en_d     = rf_en_q;
        rf_wr_d     = rf_wr_q;
        rf_sel_d    = rf_sel_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        count_d     = count_q;
        sum_clr     = 1'b0;
        wsum_en     = 1'b0;
        rsum_en     = 1'b0;

        if (ABORT) begin
            state_d     = IDLE;
            din_ready_d = 1'b0;
            rf_en_d     = 1'b0;
            rf_wr_d     = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    din_ready_d = 1'b0;
                    rf_en_d     = 1'b0;
                    rf_wr_d     = 1'b0;
                    busy_d      = 1'b0;
                    if (START) begin
                        state_d     = LOAD;
                        din_ready_d = 1'b1;
                        busy_d      = 1'b1;
                        count_d     = '0;
                        rf_sel_d    = '0;
                        err_d       = 1'b0;
                        sum_clr     = 1'b1;
                    end
                end

                LOAD: begin
                    rf_en_d = 1'b0;
                    rf_wr_d = 1'b0;
                    if (din_ready_q && DIN_VALID) begin
                        rf_in_d  = DIN;
                        rf_sel_d = count_q[SW-1:0];
                        rf_en_d  = 1'b1;
                        rf_wr_d  = 1'b1;
                        wsum_en  = 1'b1;
                        count_d  = count_q + (SW+1)'(1);
                        if (count_q == LAST_COUNT) begin
                            din_ready_d = 1'b0;
                        end
                    end else if (!din_ready_q) begin
                        // Ready only drops after the last beat, whose write lands on this edge.
                        state_d  = VERIFY;
                        rf_sel_d = '0;
                        rf_en_d  = 1'b1;
                        rf_wr_d  = 1'b0;
                    end
                end

                VERIFY: begin
                    rsum_en = 1'b1;
                    if (rf_sel_q == LAST_SEL) begin
                        state_d = CHECK;
                    end else begin
                        rf_sel_d = rf_sel_q + SW'(1);
                    end
                end

                CHECK: begin
                    state_d = IDLE;
                    err_d   = (rsum != wsum);
                    done_d  = 1'b1;
                    rf_en_d = 1'b0;
                    busy_d  = 1'b0;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            din_ready_q <= 1'b0;
            rf_in_q     <= '0;
            rf_en_q     <= 1'b0;
            rf_wr_q     <= 1'b0;
            rf_sel_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            din_ready_q <= din_ready_d;
            rf_in_q     <= rf_in_d;
            rf_en_q     <= rf_en_d;
            rf_wr_q     <= rf_wr_d;
            rf_sel_q    <= rf_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    reg_f_loader_xor_acc #(.WIDTH(WIDTH)) u_wsum (
        .clk (CLK),
        .rst (RST),
        .clr (sum_clr),
        .en  (wsum_en),
        .din (DIN),
        .acc (wsum)
    );

    reg_f_loader_xor_acc #(.WIDTH(WIDTH)) u_rsum (
        .clk (CLK),
        .rst (RST),
        .clr (sum_clr),
        .en  (rsum_en),
        .din (RF_OUT),
        .acc (rsum)
    );

    assign DIN_READY = din_ready_q;
    assign RF_IN     = rf_in_q;
    assign RF_EN     = rf_en_q;
    assign RF_WR     = rf_wr_q;
    assign RF_SEL    = rf_sel_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign COUNT     = count_q;

endmodule

// File: tb/tb_reg_f_loader.sv
// Bench for reg_f_loader with a behavioural reg_f attached; table-driven load
// runs with random data plus hand-written abort/reset/start corner cases.
module tb_reg_f_loader;

    localparam int WIDTH = 8;
    localparam int SIZE  = 9;
    localparam int SW    = $clog2(SIZE);

    logic             CLK;
    logic             RST;
    logic             START;
    logic             ABORT;
    logic [WIDTH-1:0] DIN;
    logic             DIN_VALID;
    logic             DIN_READY;
    logic [WIDTH-1:0] RF_IN;
    logic             RF_EN;
    logic             RF_WR;
    logic [SW-1:0]    RF_SEL;
    logic [WIDTH-1:0] RF_OUT;
    logic             BUSY;
    logic             DONE;
    logic             ERR;
    logic [SW:0]      COUNT;

    typedef struct {
        int valid_style;
        bit corrupt;
        bit hold_start;
        bit exp_err;
    } vec_t;

    typedef struct {
        logic [SW-1:0]    sel;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic [WIDTH-1:0] rf_mem [SIZE];
    wr_t              wr_log [$];
    int               done_total = 0;
    bit               corrupt_en = 1'b0;
    int               n_vectors = 0;
    int               n_miscompares = 0;
    vec_t             vecs [6];

    reg_f_loader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .ABORT     (ABORT),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .RF_IN     (RF_IN),
        .RF_EN     (RF_EN),
        .RF_WR     (RF_WR),
        .RF_SEL    (RF_SEL),
        .RF_OUT    (RF_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .COUNT     (COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural reg_f: registered write port, combinational read, plus a readback fault hook.
    always @(posedge CLK) begin
        if (RF_EN && RF_WR) begin
            if (RF_SEL < SW'(SIZE)) rf_mem[RF_SEL] <= RF_IN;
            wr_log.push_back('{sel: RF_SEL, data: RF_IN});
        end
        if (DONE) done_total <= done_total + 1;
    end

    always_comb begin
        RF_OUT = '0;
        if (RF_EN && RF_SEL < SW'(SIZE)) begin
            RF_OUT = rf_mem[RF_SEL];
            if (corrupt_en && !RF_WR && BUSY && RF_SEL == SW'(4)) RF_OUT[0] = ~RF_OUT[0];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic abort,
                                 input logic [WIDTH-1:0] din, input logic valid);
        START     = start;
        ABORT     = abort;
        DIN       = din;
        DIN_VALID = valid;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleZero(input string name);
        checkOutput(name, 32'({DIN_READY, RF_IN, RF_EN, RF_WR, RF_SEL, BUSY, DONE, ERR, COUNT}), 32'd0);
    endtask

    // One full load from IDLE; expectations derive from the words sent and the fault flag.
    task automatic run_load(input int style, input bit corrupt, input bit hold, input bit exp_err);
        logic [WIDTH-1:0] words [SIZE];
        int idx, cyc, log_base, done_base, n_log;
        bit v, rdy, got_done;
        for (int i = 0; i < SIZE; i++) words[i] = WIDTH'($urandom);
        log_base   = wr_log.size();
        done_base  = done_total;
        corrupt_en = corrupt;

        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick();
        checkOutput("start_busy", 32'(BUSY), 32'd1);
        checkOutput("start_ready", 32'(DIN_READY), 32'd1);
        checkOutput("start_count", 32'(COUNT), 32'd0);
        checkOutput("start_err_clear", 32'(ERR), 32'd0);

        idx = 0;
        cyc = 0;
        while (idx < SIZE && cyc < 200) begin
            if (style == 0)      v = 1'b1;
            else if (style == 1) v = (cyc % 3 == 0);
            else                 v = 1'($urandom_range(0, 1));
            applyStimulus(hold, 1'b0, words[idx], v);
            rdy = DIN_READY;
            tick();
            cyc++;
            if (v && rdy) begin
                checkOutput("wr_strobe", 32'(RF_WR), 32'd1);
                checkOutput("wr_sel", 32'(RF_SEL), 32'(idx));
                checkOutput("wr_data", 32'(RF_IN), 32'(words[idx]));
                idx++;
            end else begin
                checkOutput("gap_no_write", 32'(RF_WR), 32'd0);
            end
            checkOutput("count", 32'(COUNT), 32'(idx));
        end
        checkOutput("all_beats_accepted", 32'(idx), 32'(SIZE));
        checkOutput("ready_after_last", 32'(DIN_READY), 32'd0);
        applyStimulus(hold, 1'b0, '0, 1'b0);

        got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            tick();
            got_done = DONE;
        end
        checkOutput("done_seen", 32'(got_done), 32'd1);
        checkOutput("err_at_done", 32'(ERR), 32'(exp_err));
        checkOutput("final_count", 32'(COUNT), 32'(SIZE));
        checkOutput("busy_at_done", 32'(BUSY), 32'd0);
        tick();
        if (hold) begin
            checkOutput("restart_after_done", 32'(BUSY), 32'd1);
            applyStimulus(1'b0, 1'b1, '0, 1'b0);
            tick();
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
        end else begin
            checkOutput("done_one_cycle", 32'(DONE), 32'd0);
        end
        checkOutput("done_pulses", 32'(done_total - done_base), 32'd1);

        n_log = wr_log.size() - log_base;
        checkOutput("write_total", 32'(n_log), 32'(SIZE));
        for (int i = 0; i < SIZE && i < n_log; i++)
            checkOutput("write_order", 32'({wr_log[log_base+i].sel, wr_log[log_base+i].data}),
                        32'({SW'(i), words[i]}));
        for (int i = 0; i < SIZE; i++)
            checkOutput("regfile", 32'(rf_mem[i]), 32'(words[i]));

        repeat (3) tick();
        checkOutput("err_sticky", 32'(ERR), 32'(exp_err));
        corrupt_en = 1'b0;
    endtask

    task automatic feed_beats(input int n, output logic [WIDTH-1:0] words [SIZE]);
        for (int i = 0; i < SIZE; i++) words[i] = WIDTH'($urandom);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick();
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, words[i], 1'b1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] words [SIZE];
        logic [WIDTH-1:0] snap [SIZE];
        int done_base, cyc;
        bit in_verify;

        vecs[0] = '{valid_style: 0, corrupt: 1'b0, hold_start: 1'b0, exp_err: 1'b0};
        vecs[1] = '{valid_style: 1, corrupt: 1'b0, hold_start: 1'b0, exp_err: 1'b0};
        vecs[2] = '{valid_style: 2, corrupt: 1'b0, hold_start: 1'b0, exp_err: 1'b0};
        vecs[3] = '{valid_style: 0, corrupt: 1'b1, hold_start: 1'b0, exp_err: 1'b1};
        vecs[4] = '{valid_style: 2, corrupt: 1'b0, hold_start: 1'b1, exp_err: 1'b0};
        vecs[5] = '{valid_style: 2, corrupt: 1'b1, hold_start: 1'b0, exp_err: 1'b1};

        RST = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        repeat (3) tick();
        checkIdleZero("reset_outputs");
        RST = 1'b0;
        tick();

        for (int k = 0; k < 6; k++)
            run_load(vecs[k].valid_style, vecs[k].corrupt, vecs[k].hold_start, vecs[k].exp_err);

        // START together with ABORT in IDLE must leave the loader idle.
        applyStimulus(1'b1, 1'b1, '0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("start_abort_busy", 32'(BUSY), 32'd0);
        checkOutput("start_abort_ready", 32'(DIN_READY), 32'd0);

        // Abort after four accepted beats.
        snap = rf_mem;
        done_base = done_total;
        feed_beats(4, words);
        checkOutput("pre_abort_count", 32'(COUNT), 32'd4);
        applyStimulus(1'b0, 1'b1, '0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("abort_busy", 32'(BUSY), 32'd0);
        checkOutput("abort_wr", 32'(RF_WR), 32'd0);
        checkOutput("abort_en", 32'(RF_EN), 32'd0);
        checkOutput("abort_ready", 32'(DIN_READY), 32'd0);
        checkOutput("abort_count", 32'(COUNT), 32'd4);
        checkOutput("abort_done", 32'(DONE), 32'd0);
        repeat (15) tick();
        checkOutput("abort_count_hold", 32'(COUNT), 32'd4);
        checkOutput("abort_no_done", 32'(done_total - done_base), 32'd0);
        for (int i = 0; i < SIZE; i++)
            checkOutput("abort_regfile", 32'(rf_mem[i]), 32'(i < 4 ? words[i] : snap[i]));

        // Reset while verifying, then a clean load.
        done_base = done_total;
        feed_beats(SIZE, words);
        in_verify = 1'b0;
        for (cyc = 0; cyc < 20 && !in_verify; cyc++) begin
            in_verify = RF_EN && !RF_WR && BUSY;
            if (!in_verify) tick();
        end
        checkOutput("reached_verify", 32'(in_verify), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkIdleZero("rst_in_verify_outputs");
        repeat (15) tick();
        checkOutput("rst_no_done", 32'(done_total - done_base), 32'd0);
        run_load(0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
